// File: rtl/stopwatch_bcd.sv
// BCD stopwatch counting minutes, seconds and hundredths from an external
// clock-enable tick, with run/stop, clear and lap-freeze of the display.
module stopwatch_bcd #(
    parameter int MIN_MAX = 59
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_start_stop,
    input  logic        i_lap,
    input  logic        i_clear,
    output logic [23:0] o_disp,
    output logic        o_running,
    output logic        o_lap_active,
    output logic        o_wrap
);

    localparam logic [1:0] S_STOP = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAP  = 2'd2;

    localparam logic [3:0] MIN_H_MAX = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_L_MAX = 4'(MIN_MAX % 10);

    // Saturating compare keeps a digit from ever leaving its legal range.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] top);
        return (d >= top) ? 4'd0 : d + 4'd1;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;

    logic [3:0]  r_min_h, r_min_l, r_sec_h, r_sec_l, r_hund_h, r_hund_l;
    logic [3:0]  w_min_h_nx, w_min_l_nx, w_sec_h_nx, w_sec_l_nx, w_hund_h_nx, w_hund_l_nx;
    logic [23:0] r_lap;
    logic        r_wrap;

    logic        w_count_en;
    logic        w_clear_en;
    logic        w_hl_top, w_hh_top, w_sl_top, w_sh_top, w_ml_top, w_min_top;
    logic        w_c1, w_c2, w_c3, w_c4;
    logic        w_wrap;
    logic        w_lap_load;
    logic [23:0] w_count;
    logic [23:0] w_count_nx;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_STOP: begin
                if (i_start_stop) w_state_nx = S_RUN;
            end
            S_RUN: begin
                if (i_start_stop)   w_state_nx = S_STOP;
                else if (i_lap)     w_state_nx = S_LAP;
            end
            S_LAP: begin
                if (i_start_stop)   w_state_nx = S_STOP;
                else if (i_lap)     w_state_nx = S_RUN;
            end
            default: w_state_nx = S_STOP;
        endcase
    end

    // Counting and clearing both look at the pre-edge state only.
    assign w_count_en = i_ce && (r_state != S_STOP);
    assign w_clear_en = i_clear && (r_state == S_STOP);

    assign w_hl_top  = (r_hund_l >= 4'd9);
    assign w_hh_top  = (r_hund_h >= 4'd9);
    assign w_sl_top  = (r_sec_l  >= 4'd9);
    assign w_sh_top  = (r_sec_h  >= 4'd5);
    assign w_ml_top  = (r_min_l  >= 4'd9);
    assign w_min_top = (r_min_h > MIN_H_MAX) ||
                       ((r_min_h == MIN_H_MAX) && (r_min_l >= MIN_L_MAX));

    assign w_c1   = w_count_en & w_hl_top;
    assign w_c2   = w_c1 & w_hh_top;
    assign w_c3   = w_c2 & w_sl_top;
    assign w_c4   = w_c3 & w_sh_top;
    assign w_wrap = w_c4 & w_min_top;

    always_comb begin
        w_hund_l_nx = r_hund_l;
        w_hund_h_nx = r_hund_h;
        w_sec_l_nx  = r_sec_l;
        w_sec_h_nx  = r_sec_h;
        w_min_l_nx  = r_min_l;
        w_min_h_nx  = r_min_h;
        if (w_clear_en) begin
            w_hund_l_nx = 4'd0;
            w_hund_h_nx = 4'd0;
            w_sec_l_nx  = 4'd0;
            w_sec_h_nx  = 4'd0;
            w_min_l_nx  = 4'd0;
            w_min_h_nx  = 4'd0;
        end else begin
            if (w_count_en) w_hund_l_nx = digit_inc(r_hund_l, 4'd9);
            if (w_c1)       w_hund_h_nx = digit_inc(r_hund_h, 4'd9);
            if (w_c2)       w_sec_l_nx  = digit_inc(r_sec_l, 4'd9);
            if (w_c3)       w_sec_h_nx  = digit_inc(r_sec_h, 4'd5);
            // Minutes wrap at MIN_MAX rather than at a digit boundary.
            if (w_c4) begin
                if (w_min_top) begin
                    w_min_l_nx = 4'd0;
                    w_min_h_nx = 4'd0;
                end else begin
                    w_min_l_nx = digit_inc(r_min_l, 4'd9);
                    if (w_ml_top) w_min_h_nx = r_min_h + 4'd1;
                end
            end
        end
    end

    assign w_count    = {r_min_h, r_min_l, r_sec_h, r_sec_l, r_hund_h, r_hund_l};
    assign w_count_nx = {w_min_h_nx, w_min_l_nx, w_sec_h_nx, w_sec_l_nx, w_hund_h_nx, w_hund_l_nx};
    assign w_lap_load = (r_state == S_RUN) && (w_state_nx == S_LAP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_STOP;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hund_l <= 4'd0;
            r_hund_h <= 4'd0;
            r_sec_l  <= 4'd0;
            r_sec_h  <= 4'd0;
            r_min_l  <= 4'd0;
            r_min_h  <= 4'd0;
        end else begin
            r_hund_l <= w_hund_l_nx;
            r_hund_h <= w_hund_h_nx;
            r_sec_l  <= w_sec_l_nx;
            r_sec_h  <= w_sec_h_nx;
            r_min_l  <= w_min_l_nx;
            r_min_h  <= w_min_h_nx;
        end
    end

    // The snapshot takes the post-edge count so a coincident tick is included.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lap <= 24'd0;
        end else if (w_lap_load) begin
            r_lap <= w_count_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
        end
    end

    assign o_disp       = (r_state == S_LAP) ? r_lap : w_count;
    assign o_running    = (r_state != S_STOP);
    assign o_lap_active = (r_state == S_LAP);
    assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (MIN_MAX=1 and 59) checked every cycle
// against a model that tracks elapsed hundredths as a plain integer.
module tb_stopwatch_bcd;

    localparam int PER_A = 2 * 6000;
    localparam int PER_B = 60 * 6000;

    typedef enum int {STOPPED, RUNNING, LAPPED} mode_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        iCe, iSs, iLap, iClr;
    logic [23:0] dispA, dispB;
    logic        runA, runB, lapActA, lapActB, wrapA, wrapB;

    int          totalChecks = 0;
    int          badChecks   = 0;

    mode_t       mode;
    longint      ticks;
    longint      lapTicks;
    logic        expWrapA, expWrapB;

    stopwatch_bcd #(.MIN_MAX(1)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_ce(iCe), .i_start_stop(iSs),
        .i_lap(iLap), .i_clear(iClr), .o_disp(dispA), .o_running(runA),
        .o_lap_active(lapActA), .o_wrap(wrapA)
    );

    stopwatch_bcd dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_ce(iCe), .i_start_stop(iSs),
        .i_lap(iLap), .i_clear(iClr), .o_disp(dispB), .o_running(runB),
        .o_lap_active(lapActB), .o_wrap(wrapB)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] toBcd(input longint t, input int period);
        int v, m, s, h;
        v = int'(t % period);
        m = v / 6000;
        s = (v / 100) % 60;
        h = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mode     = STOPPED;
        ticks    = 0;
        lapTicks = 0;
        expWrapA = 1'b0;
        expWrapB = 1'b0;
    endtask

    task automatic modelStep(input logic ce, input logic ss, input logic lp, input logic clr);
        mode_t nextMode;
        logic  counted;
        if (!rstN) begin
            modelReset();
            return;
        end
        counted  = ce && (mode != STOPPED);
        nextMode = mode;
        case (mode)
            STOPPED: if (ss) nextMode = RUNNING;
            RUNNING: if (ss) nextMode = STOPPED; else if (lp) nextMode = LAPPED;
            LAPPED:  if (ss) nextMode = STOPPED; else if (lp) nextMode = RUNNING;
            default: nextMode = STOPPED;
        endcase
        if (clr && mode == STOPPED) ticks = 0;
        else if (counted) ticks++;
        expWrapA = counted && (ticks % PER_A == 0);
        expWrapB = counted && (ticks % PER_B == 0);
        if (mode == RUNNING && nextMode == LAPPED) lapTicks = ticks;
        mode = nextMode;
    endtask

    task automatic compareAll();
        longint shown;
        shown = (mode == LAPPED) ? lapTicks : ticks;
        checkOutput("dispA",   32'(dispA),   32'(toBcd(shown, PER_A)));
        checkOutput("dispB",   32'(dispB),   32'(toBcd(shown, PER_B)));
        checkOutput("runA",    32'(runA),    32'(mode != STOPPED));
        checkOutput("runB",    32'(runB),    32'(mode != STOPPED));
        checkOutput("lapActA", 32'(lapActA), 32'(mode == LAPPED));
        checkOutput("lapActB", 32'(lapActB), 32'(mode == LAPPED));
        checkOutput("wrapA",   32'(wrapA),   32'(expWrapA));
        checkOutput("wrapB",   32'(wrapB),   32'(expWrapB));
    endtask

    // One clock of stimulus: drive after a falling edge, check at the next one.
    task automatic applyStimulus(input logic ce, input logic ss, input logic lp, input logic clr);
        iCe = ce; iSs = ss; iLap = lp; iClr = clr;
        @(posedge clk);
        modelStep(ce, ss, lp, clr);
        @(negedge clk);
        iCe = 1'b0; iSs = 1'b0; iLap = 1'b0; iClr = 1'b0;
        compareAll();
    endtask

    initial begin
        rstN = 1'b0;
        iCe = 1'b0; iSs = 1'b0; iLap = 1'b0; iClr = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;
        repeat (5) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("resetIdle", 32'(dispA), 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (123) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("start123", 32'(dispA), 32'h000123);
        checkOutput("running123", 32'(runA), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stopHold", 32'(dispA), 32'h000123);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clearStop", 32'(dispA), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (250) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lapFrozen", 32'(dispA), 32'h000250);
        checkOutput("lapActive", 32'(lapActA), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("lapRelease", 32'(dispA), 32'h000350);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clearInRun", 32'(dispA), 32'h000350);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ssLapStop", 32'(runA), 32'h0);
        checkOutput("ssLapNoLap", 32'(lapActA), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("clearStartZero", 32'(dispA), 32'h0);
        checkOutput("clearStartRun", 32'(runA), 32'h1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ceOnStart", 32'(dispA), 32'h000003);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ceOnStop", 32'(dispA), 32'h000004);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (11999) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("preWrap", 32'(dispA), 32'h015999);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrapZero", 32'(dispA), 32'h0);
        checkOutput("wrapPulse", 32'(wrapA), 32'h1);
        checkOutput("noWrapB", 32'(dispB), 32'h020000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrapOneCycle", 32'(wrapA), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4217) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("at4217", 32'(dispA), 32'h004217);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncDisp", 32'(dispA), 32'h0);
        checkOutput("asyncRun", 32'(runA), 32'h0);
        compareAll();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("postResetStop", 32'(dispA), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic rCe, rSs, rLp, rClr;
            rCe  = ($urandom_range(0, 99) < 60);
            rSs  = ($urandom_range(0, 99) < 4);
            rLp  = ($urandom_range(0, 99) < 6);
            rClr = ($urandom_range(0, 99) < 5);
            applyStimulus(rCe, rSs, rLp, rClr);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
